ahb_boot_ram: RTL and testbench
===============================

Name: ahb_boot_ram

Overview:
- AHB-Lite slave wrapping a single-port, word-organised on-chip RAM.
- Destination of the SPI bootloader's AHB-Lite write stream, which copies the program image starting at 0x200.
- After boot, the core reads the same image through this port.
- Supports byte, halfword and word accesses with byte lanes, inserts wait states only on read-after-write port conflicts, and returns two-cycle ERROR responses for illegal transfers.

Parameters:
- MEM_WORDS, 8192, RAM depth in 32-bit words (32 KB); legal byte addresses are 0 to MEM_WORDS*4-1.
- AW, 13, word-index width; must equal clog2(MEM_WORDS).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- hsel  in  1  slave select.
- haddr  in  32  byte address (address phase).
- hwrite  in  1  1 = write, 0 = read.
- hsize  in  3  0 = byte, 1 = halfword, 2 = word; others illegal.
- hburst  in  3  ignored; every beat is treated as an independent transfer.
- hmastlock  in  1  ignored.
- hprot  in  4  ignored.
- htrans  in  2  IDLE 0, BUSY 1, NONSEQ 2, SEQ 3.
- hwdata  in  32  write data (data phase).
- hready  in  1  bus-level ready (HREADYIN).
- hreadyout  out  1  slave ready.
- hresp  out  1  0 = OKAY, 1 = ERROR.
- hrdata  out  32  read data.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE, hreadyout = 1, hresp = 0, hrdata = 0.
  - Captured address-phase registers are cleared.
  - RAM contents are NOT cleared.
  - Reset mid-transfer abandons any pending write; the write is never performed.
- Transfer acceptance: address phase accepted on a rising edge where hsel=1, hready=1 and htrans[1]=1.
  - Capture haddr[AW+1:0], hwrite and hsize.
  - IDLE/BUSY or hsel=0: next data phase is OKAY with zero wait states and no RAM access.
- Legality check (at acceptance):
  - Illegal if haddr >= MEM_WORDS*4, or hsize > 2.
  - Illegal if misaligned: hsize = 1 with haddr[0] = 1, or hsize = 2 with haddr[1:0] != 0.
  - An illegal transfer goes to ERR1.
- States:
  - IDLE: hreadyout = 1, hresp = 0.
  - WR: write data phase. hreadyout = 1. RAM is written on the edge ending the phase with hwdata masked by byte enables.
  - RD: read data phase. hreadyout = 1. hrdata = RAM word read synchronously using the address presented during the address phase.
  - RDW: read wait. hreadyout = 0 for exactly one cycle, then moves to RD.
  - ERR1: hresp = 1, hreadyout = 0.
  - ERR2: hresp = 1, hreadyout = 1. Next state is set by the transfer accepted during ERR2, if any.
- Byte enables:
  - byte: bit (1 << haddr[1:0]).
  - halfword: 4'b0011 or 4'b1100 selected by haddr[1].
  - word: 4'b1111.
  - Unselected lanes retain old contents.
- Read-after-write port conflict: a read address phase accepted during a WR data phase cannot use the RAM port that cycle.
  - The read goes to RDW (1 wait state).
  - The read is then performed with the written data already visible (no stale data).
- Back-to-back:
  - A write following a write, or a read following a read, runs with zero wait states.
  - A write following a read runs with zero wait states.
- Read data: hrdata always returns the full 32-bit word; the master selects lanes. hrdata holds its last value outside RD.
- Next address phase: while hreadyout = 0 (RDW or ERR1) no new address phase is accepted, since hready is low bus-wide.
- Wrap: no wrap-around; out-of-range addresses give ERROR and never alias into the RAM.

Test Plan:
- Reset with reset=0 mid-WR (haddr 0x200, hwdata 0x11223344) -> hreadyout=1, hresp=0, hrdata=0; later read of 0x200 returns the prior contents, not 0x11223344.
- Loader-style stream: NONSEQ word writes 0xDEADBEEF @0x200 and 0xCAFEF00D @0x204, then reads of the same addresses -> zero wait on writes; hrdata 0xDEADBEEF then 0xCAFEF00D.
- Write 0xAABBCCDD @0x300 immediately followed by a read @0x300 -> exactly one cycle of hreadyout=0, then hrdata=0xAABBCCDD.
- Sub-word writes: byte 0x5A @0x401 and halfword 0x1234 @0x406 onto words preset to 0 -> reads return 0x00005A00 @0x400 and 0x12340000 @0x404.
- Errors: word read @0x8000 (MEM_WORDS=8192), word write @0x202, hsize=3 -> each gives ERR1 (hresp=1, hreadyout=0) then ERR2 (hresp=1, hreadyout=1); RAM unchanged.
- IDLE and BUSY htrans, plus hsel=0 with a NONSEQ write @0x200 -> OKAY, zero wait states, no RAM change.

Source files
------------

// File: rtl/ahb_boot_ram.sv
// AHB-Lite slave over a single-port word RAM with byte lanes; one wait state on read-after-write,
// two-cycle ERROR response for out-of-range, misaligned or oversized transfers.
module ahb_boot_ram #(
  parameter int MEM_WORDS = 8192,
  parameter int AW        = 13
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hsel,
  input  logic [31:0] haddr,
  input  logic        hwrite,
  input  logic [2:0]  hsize,
  input  logic [2:0]  hburst,
  input  logic        hmastlock,
  input  logic [3:0]  hprot,
  input  logic [1:0]  htrans,
  input  logic [31:0] hwdata,
  input  logic        hready,
  output logic        hreadyout,
  output logic        hresp,
  output logic [31:0] hrdata
);

  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RDW, S_ERR1, S_ERR2} state_e;

  state_e        state_q, state_d;
  logic [AW+1:0] addr_q, addr_d;
  logic [1:0]    size_q, size_d;
  logic [31:0]   rdata_q;
  logic [31:0]   mem [MEM_WORDS];

  logic          accept, legal, size_ok, ram_we, ram_re;
  logic [AW-1:0] ram_addr;
  logic [3:0]    be;
  logic          unused_ok;

  assign unused_ok = ^{hburst, hmastlock, hprot, htrans[0]};

  assign accept = hsel && hready && htrans[1];

  always_comb begin
    size_ok = 1'b0;
    case (hsize)
      3'd0:    size_ok = 1'b1;
      3'd1:    size_ok = !haddr[0];
      3'd2:    size_ok = (haddr[1:0] == 2'b00);
      default: size_ok = 1'b0;
    endcase
  end

  // Full 32-bit compare so high address bits can never alias into the array.
  assign legal = size_ok && (haddr < 32'(MEM_WORDS * 4));

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    case (state_q)
      S_RDW:  state_d = S_RD;
      S_ERR1: state_d = S_ERR2;
      default: begin
        if (hready) begin
          if (accept) begin
            addr_d = haddr[AW+1:0];
            size_d = hsize[1:0];
            if (!legal)               state_d = S_ERR1;
            else if (hwrite)          state_d = S_WR;
            else if (state_q == S_WR) state_d = S_RDW;
            else                      state_d = S_RD;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      size_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
    end
  end

  always_comb begin
    be = 4'b0000;
    case (size_q)
      2'd0:    be = 4'b0001 << addr_q[1:0];
      2'd1:    be = addr_q[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // The port is busy with the write during WR, so a read accepted then is replayed from RDW.
  assign ram_we   = (state_q == S_WR) && hready;
  assign ram_re   = (state_q == S_RDW) ||
                    (accept && legal && !hwrite &&
                     (state_q == S_IDLE || state_q == S_RD || state_q == S_ERR2));
  assign ram_addr = (state_q == S_RDW) ? addr_q[AW+1:2] : haddr[AW+1:2];

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr_q[AW+1:2]][8*b +: 8] <= hwdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      rdata_q <= '0;
    else if (ram_re) rdata_q <= mem[ram_addr];
  end

  assign hreadyout = !(state_q == S_RDW || state_q == S_ERR1);
  assign hresp     = (state_q == S_ERR1 || state_q == S_ERR2);
  assign hrdata    = rdata_q;

endmodule

// File: tb/tb_ahb_boot_ram.sv
// Bench for ahb_boot_ram: byte-addressed memory model plus per-transfer response queue,
// checked every cycle, with directed scenarios followed by randomized traffic.
module tb_ahb_boot_ram;
  localparam int MEM_WORDS = 8192;

  logic        clk = 0, reset = 0, hsel = 0, hwrite = 0, hmastlock = 0;
  logic [31:0] haddr = 0, hwdata = 0;
  logic [2:0]  hsize = 0, hburst = 0;
  logic [3:0]  hprot = 0;
  logic [1:0]  htrans = 0;
  logic        hready, hreadyout, hresp;
  logic [31:0] hrdata;

  assign hready = hreadyout;

  ahb_boot_ram #(.MEM_WORDS(MEM_WORDS), .AW(13)) dut (
    .clk(clk), .reset(reset), .hsel(hsel), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot),
    .htrans(htrans), .hwdata(hwdata), .hready(hready),
    .hreadyout(hreadyout), .hresp(hresp), .hrdata(hrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rdy;
    bit          resp;
    bit          upd;
    logic [31:0] data;
    logic [31:0] mask;
  } exp_t;

  exp_t          exp_q[$];
  bit            cur_rdy = 1;
  logic [31:0]   m_rdata = 0, m_mask = 32'hFFFF_FFFF;
  byte unsigned  mem_b [int];
  bit            wr_pend = 0;
  int            wr_addr = 0, wr_size = 0;
  int            checks = 0, errors = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] expv, logic [31:0] mask = 32'hFFFF_FFFF);
    checks++;
    if (((act ^ expv) & mask) !== 32'h0) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (mask %h) at %0t", name, act, expv, mask, $time);
    end
  endtask

  function automatic bit legal_f(logic [31:0] a, logic [2:0] s);
    if (s > 3'd2) return 0;
    return (a < MEM_WORDS * 4) && ((a % (1 << s)) == 0);
  endfunction

  function automatic logic [31:0] word_f(int a);
    logic [31:0] w;
    w = 0;
    for (int i = 0; i < 4; i++)
      if (mem_b.exists((a & ~3) + i)) w[8*i +: 8] = mem_b[(a & ~3) + i];
    return w;
  endfunction

  function automatic logic [31:0] mask_f(int a);
    logic [31:0] m;
    m = 0;
    for (int i = 0; i < 4; i++)
      if (mem_b.exists((a & ~3) + i)) m[8*i +: 8] = 8'hFF;
    return m;
  endfunction

  // At each edge that closes a data phase: retire the pending write, then queue the
  // per-cycle responses of the transfer whose address phase is on the bus.
  task automatic model_step();
    bit   was_wr;
    int   a;
    exp_t e;
    if (!reset) begin
      exp_q.delete();
      wr_pend = 0;
    end else if (cur_rdy) begin
      was_wr = wr_pend;
      if (wr_pend) begin
        for (int i = 0; i < (1 << wr_size); i++) begin
          a = wr_addr + i;
          mem_b[a] = hwdata[8*(a % 4) +: 8];
        end
      end
      wr_pend = 0;
      if (hsel && htrans[1]) begin
        if (!legal_f(haddr, hsize)) begin
          e = '{0, 1, 0, 0, 0}; exp_q.push_back(e);
          e = '{1, 1, 0, 0, 0}; exp_q.push_back(e);
        end else if (hwrite) begin
          e = '{1, 0, 0, 0, 0}; exp_q.push_back(e);
          wr_pend = 1;
          wr_addr = int'(haddr);
          wr_size = int'(hsize);
        end else begin
          if (was_wr) begin e = '{0, 0, 0, 0, 0}; exp_q.push_back(e); end
          e = '{1, 0, 1, word_f(int'(haddr)), mask_f(int'(haddr))};
          exp_q.push_back(e);
        end
      end else begin
        e = '{1, 0, 0, 0, 0}; exp_q.push_back(e);
      end
    end
  endtask

  task automatic compare_step();
    exp_t e;
    if (!reset) begin
      cur_rdy = 1;
      m_rdata = 0;
      m_mask  = 32'hFFFF_FFFF;
      check("rst_hreadyout", {31'b0, hreadyout}, 32'd1);
      check("rst_hresp",     {31'b0, hresp},     32'd0);
      check("rst_hrdata",    hrdata,             32'd0);
    end else begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = '{1, 0, 0, 0, 0};
      if (e.upd) begin
        m_rdata = e.data;
        m_mask  = e.mask;
      end
      cur_rdy = e.rdy;
      check("hreadyout", {31'b0, hreadyout}, {31'b0, e.rdy});
      check("hresp",     {31'b0, hresp},     {31'b0, e.resp});
      check("hrdata",    hrdata,             m_rdata, m_mask);
    end
  endtask

  initial forever begin
    @(posedge clk); model_step();
    @(negedge clk); compare_step();
  end

  task automatic xfer(bit sel, logic [1:0] tr, bit wr, logic [2:0] sz, logic [31:0] a, logic [31:0] wd);
    int n;
    n = 0;
    hsel = sel; htrans = tr; hwrite = wr; hsize = sz; haddr = a;
    do begin
      @(posedge clk);
      n++;
    end while (!cur_rdy && n < 8);
    if (!cur_rdy) begin
      checks++; errors++;
      $display("FAIL accept_timeout: address phase @%h still stalled after %0d cycles", a, n);
    end
    #1;
    hwdata = wr ? wd : $urandom;
  endtask

  task automatic idle();
    xfer(0, 2'd0, 0, 3'd2, 32'h0, 32'h0);
  endtask

  task automatic wr32(logic [31:0] a, logic [31:0] d); xfer(1, 2'd2, 1, 3'd2, a, d); endtask
  task automatic rd32(logic [31:0] a);                 xfer(1, 2'd2, 0, 3'd2, a, 32'h0); endtask

  task automatic hrdata_is(string name, logic [31:0] v);
    @(negedge clk);
    check(name, hrdata, v);
  endtask

  task automatic err_seq(string name, bit wr, logic [2:0] sz, logic [31:0] a);
    xfer(1, 2'd2, wr, sz, a, 32'hFFFF_FFFF);
    hsel = 0; htrans = 2'd0;
    @(negedge clk);
    check({name, "_err1_rdy"},  {31'b0, hreadyout}, 32'd0);
    check({name, "_err1_resp"}, {31'b0, hresp},     32'd1);
    @(negedge clk);
    check({name, "_err2_rdy"},  {31'b0, hreadyout}, 32'd1);
    check({name, "_err2_resp"}, {31'b0, hresp},     32'd1);
    @(posedge clk); #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [2:0]  sz;
    logic [1:0]  tr;
    bit          sel, wr;

    repeat (3) @(posedge clk);
    #1 reset = 1;

    // Known contents, then a read so hrdata is nonzero before reset.
    wr32(32'h200, 32'h0BAD_F00D);
    wr32(32'h400, 32'h0);
    wr32(32'h404, 32'h0);
    rd32(32'h200);
    idle();

    // Reset in the middle of a write data phase abandons that write.
    wr32(32'h200, 32'h1122_3344);
    hsel = 0; htrans = 2'd0;
    #2 reset = 0;
    @(posedge clk); @(posedge clk);
    #1 reset = 1;
    rd32(32'h200);
    idle();
    hrdata_is("after_rst_200", 32'h0BAD_F00D);
    check("model_after_rst_200", word_f(32'h200), 32'h0BAD_F00D);

    // Loader-style stream and read-back.
    wr32(32'h200, 32'hDEAD_BEEF);
    wr32(32'h204, 32'hCAFE_F00D);
    rd32(32'h200);
    rd32(32'h204);
    idle();
    hrdata_is("loader_204", 32'hCAFE_F00D);

    // Read immediately after write to the same word.
    wr32(32'h300, 32'hAABB_CCDD);
    rd32(32'h300);
    @(negedge clk);
    check("raw_wait_rdy", {31'b0, hreadyout}, 32'd0);
    hsel = 0; htrans = 2'd0;
    @(negedge clk);
    check("raw_rd_rdy", {31'b0, hreadyout}, 32'd1);
    check("raw_rd_data", hrdata, 32'hAABB_CCDD);
    @(posedge clk); #1;

    // Sub-word writes with data replicated across lanes to expose bad masking.
    xfer(1, 2'd2, 1, 3'd0, 32'h401, 32'h5A5A_5A5A);
    xfer(1, 2'd2, 1, 3'd1, 32'h406, 32'h1234_1234);
    rd32(32'h400);
    idle();
    hrdata_is("byte_400", 32'h0000_5A00);
    rd32(32'h404);
    idle();
    hrdata_is("half_404", 32'h1234_0000);
    check("model_400", word_f(32'h400), 32'h0000_5A00);
    check("model_404", word_f(32'h404), 32'h1234_0000);

    // Illegal transfers, then confirm the RAM kept its contents.
    err_seq("oob_rd",   0, 3'd2, 32'h8000);
    err_seq("misal_wr", 1, 3'd2, 32'h202);
    err_seq("size3",    0, 3'd3, 32'h200);
    err_seq("oob_hi",   1, 3'd0, 32'h8000_0200);
    xfer(1, 2'd2, 1, 3'd0, 32'h7FFF, 32'h9999_9999);
    rd32(32'h7FFC);
    idle();
    rd32(32'h200);
    idle();
    hrdata_is("after_err_200", 32'hDEAD_BEEF);

    // IDLE, BUSY and deselected transfers leave the RAM alone.
    xfer(1, 2'd0, 1, 3'd2, 32'h200, 32'h0101_0101);
    xfer(1, 2'd1, 1, 3'd2, 32'h200, 32'h0202_0202);
    xfer(0, 2'd2, 1, 3'd2, 32'h200, 32'h0303_0303);
    rd32(32'h200);
    idle();
    hrdata_is("nosel_200", 32'hDEAD_BEEF);

    // Randomized traffic over a small window plus the top of the address range.
    for (int k = 0; k < 600; k++) begin
      sz = ($urandom_range(0, 15) == 0) ? 3'd3 : 3'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) a = 32'h7FF0 + $urandom_range(0, 31);
      else                           a = 32'h200 + $urandom_range(0, 63);
      if (sz != 3'd3 && $urandom_range(0, 7) != 0) a = a & ~((32'd1 << sz) - 32'd1);
      tr  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(0, 1)) : 2'($urandom_range(2, 3));
      sel = ($urandom_range(0, 9) != 0);
      wr  = $urandom_range(0, 1) == 1;
      xfer(sel, tr, wr, sz, a, $urandom);
    end
    idle();
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
